// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between fetch_unit and imem.
// Master launches fetches; slave returns one word per ack pulse.
interface fetch_unit_if #(
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: PC, imem req/ack fetch, one-entry skid and IF/ID register.
// Redirects on jump / taken branch resolved in EX.
module fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              ex_jump,
  input  logic              ex_beq,
  input  logic              ex_bne,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_target,
  output logic              redirect,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc_plus2,
  output logic              if_id_valid,
  output logic [3:0]        opcode
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [DATA_W-1:0] TWO = DATA_W'(2);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc2;
  } if_id_t;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  if_id_t            ifid_q, ifid_d;
  logic              valid_q, valid_d;
  if_id_t            skid_q, skid_d;

  logic              ack;
  logic              accept;
  logic              launch;
  logic [DATA_W-1:0] launch_addr;
  if_id_t            fetched;

  assign redirect = ex_jump
                  | (ex_beq & ex_zero)
                  | (ex_bne & ~ex_zero);

  // An ack only counts against a live request.
  assign ack     = imem.imem_ack & req_q;
  assign accept  = ~stall | ~valid_q;
  assign fetched = '{instr: imem.imem_rdata,
                     pc2:   addr_q + TWO};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    ifid_d      = ifid_q;
    valid_d     = valid_q;
    skid_d      = skid_q;
    launch      = 1'b0;
    launch_addr = pc_q;

    unique case (state_q)
      S_IDLE: begin
        launch = 1'b1;
        if (redirect) launch_addr = ex_target;
      end
      S_REQ: begin
        if (redirect) begin
          if (ack) begin
            launch      = 1'b1;
            launch_addr = ex_target;
          end else begin
            pc_d    = ex_target;
            state_d = S_DROP;
          end
        end else if (ack) begin
          if (accept) begin
            ifid_d  = fetched;
            valid_d = 1'b1;
            launch  = 1'b1;
          end else begin
            skid_d  = fetched;
            req_d   = 1'b0;
            state_d = S_FULL;
          end
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      S_DROP: begin
        valid_d = 1'b0;
        if (ack) begin
          launch = 1'b1;
          if (redirect) launch_addr = ex_target;
        end else if (redirect) begin
          pc_d = ex_target;
        end
      end
      S_FULL: begin
        if (redirect) begin
          launch      = 1'b1;
          launch_addr = ex_target;
        end else if (accept) begin
          ifid_d  = skid_q;
          valid_d = 1'b1;
          launch  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) valid_d = 1'b0;

    if (launch) begin
      addr_d  = launch_addr;
      req_d   = 1'b1;
      pc_d    = launch_addr + TWO;
      state_d = S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      ifid_q  <= '0;
      valid_q <= 1'b0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus2 = ifid_q.pc2;
  assign if_id_valid    = valid_q;
  assign opcode         = ifid_q.instr[DATA_W-1 -: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem model returns 0x1000|addr,
// IF/ID entries consumed by ID are checked against a scoreboard queue.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        ex_jump = 1'b0;
  logic        ex_beq = 1'b0;
  logic        ex_bne = 1'b0;
  logic        ex_zero = 1'b0;
  logic [15:0] ex_target = 16'h0000;
  logic        auto_ack = 1'b1;
  logic        man_ack = 1'b0;

  logic        redirect;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic [3:0]  opcode;

  fetch_unit_if #(.DATA_W(16)) m ();
  assign m.imem_ack   = auto_ack ? m.imem_req : man_ack;
  assign m.imem_rdata = 16'h1000 | m.imem_addr;

  fetch_unit #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (m),
    .stall          (stall),
    .ex_jump        (ex_jump),
    .ex_beq         (ex_beq),
    .ex_bne         (ex_bne),
    .ex_zero        (ex_zero),
    .ex_target      (ex_target),
    .redirect       (redirect),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .opcode         (opcode)
  );

  // Second instance exercises the 0xFFFE -> 0x0000 wrap.
  logic        w_tie = 1'b0;
  logic [15:0] w_tgt = 16'h0000;
  logic        w_redirect;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [15:0] w_pc2;
  logic [3:0]  w_opcode;

  fetch_unit_if #(.DATA_W(16)) wm ();
  assign wm.imem_ack   = wm.imem_req;
  assign wm.imem_rdata = 16'h1000 | wm.imem_addr;

  fetch_unit #(.DATA_W(16), .RESET_PC(16'hFFFE)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (wm),
    .stall          (w_tie),
    .ex_jump        (w_tie),
    .ex_beq         (w_tie),
    .ex_bne         (w_tie),
    .ex_zero        (w_tie),
    .ex_target      (w_tgt),
    .redirect       (w_redirect),
    .if_id_instr    (w_instr),
    .if_id_pc_plus2 (w_pc2),
    .if_id_valid    (w_valid),
    .opcode         (w_opcode)
  );

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] ent(input logic [15:0] a);
    return {16'h1000 | a, a + 16'd2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ID consumes IF/ID on a valid, unstalled, non-flushed cycle.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n && if_id_valid && !stall && !redirect) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%h expected=none", if_id_instr);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_instr", if_id_instr, e[31:16]);
        chk("sb_pc2", if_id_pc_plus2, e[15:0]);
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", {15'd0, m.imem_req}, 16'h0000);
    chk("rst_addr", m.imem_addr, 16'h0000);
    chk("rst_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc2", if_id_pc_plus2, 16'h0000);
    chk("rst_w_addr", wm.imem_addr, 16'hFFFE);
    #10 rst_n = 1'b1;

    step();
    chk("l0_addr", m.imem_addr, 16'h0000);
    chk("l0_req", {15'd0, m.imem_req}, 16'h0001);
    chk("l0_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("w_l0_addr", wm.imem_addr, 16'hFFFE);
    sb.push_back(ent(16'h0000));
    sb.push_back(ent(16'h0002));

    step();
    chk("s1_instr", if_id_instr, 16'h1000);
    chk("s1_pc2", if_id_pc_plus2, 16'h0002);
    chk("s1_opcode", {12'd0, opcode}, 16'h0001);
    chk("s1_valid", {15'd0, if_id_valid}, 16'h0001);
    chk("s1_addr", m.imem_addr, 16'h0002);
    chk("w_instr", w_instr, 16'hFFFE);
    chk("w_pc2_wrap", w_pc2, 16'h0000);
    chk("w_addr_wrap", wm.imem_addr, 16'h0000);

    step();
    chk("s2_instr", if_id_instr, 16'h1002);
    chk("w2_pc2", w_pc2, 16'h0002);

    step();
    chk("s3_instr", if_id_instr, 16'h1004);
    chk("s3_addr", m.imem_addr, 16'h0006);
    auto_ack = 1'b0;
    ex_beq = 1'b1;
    ex_zero = 1'b1;
    ex_target = 16'h0040;
    #1;
    chk("beq_redirect", {15'd0, redirect}, 16'h0001);

    step();
    chk("drop_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("drop_addr", m.imem_addr, 16'h0006);
    chk("drop_req", {15'd0, m.imem_req}, 16'h0001);
    chk("drop_instr_kept", if_id_instr, 16'h1004);
    ex_beq = 1'b0;
    ex_zero = 1'b0;

    step();
    chk("drop2_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("drop2_addr", m.imem_addr, 16'h0006);

    step();
    man_ack = 1'b1;

    step();
    man_ack = 1'b0;
    auto_ack = 1'b1;
    chk("tgt_addr", m.imem_addr, 16'h0040);
    chk("tgt_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("tgt_req", {15'd0, m.imem_req}, 16'h0001);
    sb.push_back(ent(16'h0040));

    step();
    chk("t0_instr", if_id_instr, 16'h1040);
    chk("t0_valid", {15'd0, if_id_valid}, 16'h0001);
    chk("t0_addr", m.imem_addr, 16'h0042);
    ex_beq = 1'b1;
    ex_zero = 1'b0;
    ex_target = 16'h0040;
    #1;
    chk("nt_redirect", {15'd0, redirect}, 16'h0000);
    sb.push_back(ent(16'h0042));

    step();
    chk("nt_instr", if_id_instr, 16'h1042);
    chk("nt_addr", m.imem_addr, 16'h0044);
    ex_beq = 1'b0;
    stall = 1'b1;

    step();
    chk("st_req", {15'd0, m.imem_req}, 16'h0000);
    chk("st_instr", if_id_instr, 16'h1042);
    chk("st_valid", {15'd0, if_id_valid}, 16'h0001);

    step();
    step();
    chk("st3_instr", if_id_instr, 16'h1042);
    chk("st3_req", {15'd0, m.imem_req}, 16'h0000);
    stall = 1'b0;
    sb.push_back(ent(16'h0044));

    step();
    chk("sk_instr", if_id_instr, 16'h1044);
    chk("sk_pc2", if_id_pc_plus2, 16'h0046);
    chk("sk_addr", m.imem_addr, 16'h0046);
    chk("sk_req", {15'd0, m.imem_req}, 16'h0001);

    step();
    chk("j0_instr", if_id_instr, 16'h1046);
    chk("j0_addr", m.imem_addr, 16'h0048);
    ex_jump = 1'b1;
    ex_target = 16'h0080;
    stall = 1'b1;

    step();
    chk("j_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("j_addr", m.imem_addr, 16'h0080);
    chk("j_req", {15'd0, m.imem_req}, 16'h0001);
    chk("j_instr_kept", if_id_instr, 16'h1046);
    ex_jump = 1'b0;
    stall = 1'b0;
    sb.push_back(ent(16'h0080));

    step();
    chk("j1_instr", if_id_instr, 16'h1080);
    chk("j1_valid", {15'd0, if_id_valid}, 16'h0001);
    chk("j1_addr", m.imem_addr, 16'h0082);
    chk("j1_req", {15'd0, m.imem_req}, 16'h0001);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", {15'd0, m.imem_req}, 16'h0000);
    chk("ar_addr", m.imem_addr, 16'h0000);
    chk("ar_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("ar_instr", if_id_instr, 16'h0000);
    chk("ar_pc2", if_id_pc_plus2, 16'h0000);
    chk("ar_opcode", {12'd0, opcode}, 16'h0000);
    chk("ar_w_addr", wm.imem_addr, 16'hFFFE);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
